// File: rtl/bitwise16_stage_pkg.sv
// Shared definitions for the 16-bit bitwise pipeline stage: opcode encoding
// and default sizing.
package bitwise16_stage_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned OPCNT_W   = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

endpackage

// File: rtl/bitwise16_stage_sync_fifo.sv
// Synchronous FIFO with occupancy count and free-running wrap-around pointers.
// Writes when full and reads when empty are ignored.
module bitwise16_stage_sync_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          wr_fire;
  logic          rd_fire;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_fire = wr_en_i & ~full;
  assign rd_fire = rd_en_i & ~empty_o;

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only observable after it is written.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/bitwise16_stage.sv
// Registered bitwise-logic stage: computes AND/OR/XOR/NAND with zero/negative
// flags and queues results for a possibly stalling writeback consumer.
module bitwise16_stage
  import bitwise16_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid must not depend on ready, and in_ready comes from state only.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zr,
  output logic               out_ng,
  output logic [OPCNT_W-1:0] op_count
);

  localparam int unsigned EW = WIDTH + 2;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   result;
  logic               res_zr;
  logic               res_ng;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      head;
  logic [EW-1:0]      last_q, last_d;
  logic [OPCNT_W-1:0] op_count_q, op_count_d;

  always_comb begin
    result = '0;
    case (op_e'(in_op))
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_NAND: result = ~(in_a & in_b);
      default: result = '0;
    endcase
  end

  assign res_zr = (result == '0);
  assign res_ng = result[WIDTH-1];

  assign in_ready  = (fifo_count < CW'(DEPTH));
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  bitwise16_stage_sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_data_i ({res_ng, res_zr, result}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  // When empty the outputs show the most recently consumed entry.
  always_comb begin
    last_d     = last_q;
    op_count_d = op_count_q;
    if (pop)  last_d     = head;
    if (push) op_count_d = op_count_q + OPCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      op_count_q <= '0;
    end else begin
      last_q     <= last_d;
      op_count_q <= op_count_d;
    end
  end

  assign {out_ng, out_zr, out_data} = out_valid ? head : last_q;
  assign op_count                   = op_count_q;

endmodule

// File: tb/tb_bitwise16_stage.sv
// Bench for bitwise16_stage: directed vector table, backpressure, streaming and
// mid-stream reset, with a queue-based scoreboard on the output handshake.
module tb_bitwise16_stage;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zr;
  logic          out_ng;
  logic [15:0]   op_count;

  int checks;
  int errors;
  int sb_pops;
  logic [W+1:0] exp_q[$];

  bitwise16_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zr    (out_zr),
    .out_ng    (out_ng),
    .op_count  (op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    logic [W-1:0] r;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~(a & b);
    endcase
    return {r[W-1], (r == 0), r};
  endfunction

  // scoreboard: compare on each output transfer, then record each input transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          sb_pops++;
          check("sb_data", {16'd0, out_data}, {16'd0, e[W-1:0]});
          check("sb_zr", {31'd0, out_zr}, {31'd0, e[W]});
          check("sb_ng", {31'd0, out_ng}, {31'd0, e[W+1]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_data;
    logic         exp_zr;
    logic         exp_ng;
  } vec_t;

  vec_t vecs[5];

  initial begin
    checks    = 0;
    errors    = 0;
    sb_pops   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'd0;
    out_ready = 1'b0;

    vecs[0] = '{16'hF0F0, 16'hFF00, 2'd0, 16'hF000, 1'b0, 1'b1};
    vecs[1] = '{16'hF0F0, 16'hFF00, 2'd1, 16'hFFF0, 1'b0, 1'b1};
    vecs[2] = '{16'hF0F0, 16'hFF00, 2'd2, 16'h0FF0, 1'b0, 1'b0};
    vecs[3] = '{16'hF0F0, 16'hFF00, 2'd3, 16'h0FFF, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'hFF00, 2'd0, 16'h0000, 1'b1, 1'b0};

    // 1: reset values
    #7;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_zr", {31'd0, out_zr}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2/3: single ops from the table
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_data", {16'd0, out_data}, {16'd0, vecs[i].exp_data});
      check("vec_zr", {31'd0, out_zr}, {31'd0, vecs[i].exp_zr});
      check("vec_ng", {31'd0, out_ng}, {31'd0, vecs[i].exp_ng});
      tick();
      check("vec_empty", {31'd0, out_valid}, 32'd0);
      check("vec_hold", {16'd0, out_data}, {16'd0, vecs[i].exp_data});
    end
    check("vec_op_count", {16'd0, op_count}, 32'd5);

    // 4: backpressure with a 2-deep queue
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_op = 2'd0;
    tick();
    in_a = 16'h0002; in_b = 16'h0000; in_op = 2'd1;
    tick();
    in_a = 16'h0003; in_b = 16'h0001; in_op = 2'd2;
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head", {16'd0, out_data}, 32'h0001);
    tick();
    check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    check("bp_stall_head", {16'd0, out_data}, 32'h0001);
    check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_drain1", {16'd0, out_data}, 32'h0002);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_drain2", {16'd0, out_data}, 32'h0002);
    check("bp_drain2_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_op_count", {16'd0, op_count}, 32'd8);

    // 5: streaming from a fresh reset
    do_reset();
    sb_pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_a  = W'($urandom_range(0, 16'hFFFF));
      in_b  = W'($urandom_range(0, 16'hFFFF));
      in_op = 2'($urandom_range(0, 3));
      tick();
      check("stream_count_le1", {31'd0, (dut.u_fifo.count_q <= 2'd1)}, 32'd1);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_op_count", {16'd0, op_count}, 32'd20);
    check("stream_pops", sb_pops, 32'd20);
    check("stream_sb_empty", exp_q.size(), 32'd0);
    check("stream_out_empty", {31'd0, out_valid}, 32'd0);

    // 6: asynchronous reset with two entries queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h00FF; in_op = 2'd1;
    tick();
    in_a = 16'h8000; in_b = 16'hFFFF; in_op = 2'd0;
    tick();
    in_valid = 1'b0;
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_valid_drop", {31'd0, out_valid}, 32'd0);
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_out_data", {16'd0, out_data}, 32'd0);
    check("mid_op_count", {16'd0, op_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_empty", {31'd0, out_valid}, 32'd0);
    check("post_rst_op_count", {16'd0, op_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
